// File: rtl/add_slice_sched.sv
// rtl/add_slice_sched.sv - round-robin scheduler sharing one SLICE-bit adder across two requesters
// Operands shift right one slice per cycle; the sum shifts in from the top so slice 0 lands at bit 0.
module add_slice_sched #(
   parameter int WIDTH = 12,
   parameter int SLICE = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH:0]   rsp_sum,
   output logic             rsp_id,
   output logic             busy
);
   localparam int NSLC = WIDTH / SLICE;
   localparam int KW   = (NSLC > 1) ? $clog2(NSLC) : 1;

   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH:0]   r_sum;
   logic [KW-1:0]    r_k;
   logic             r_carry;
   logic             r_rr;
   logic             r_id;
   logic             r_rsp_valid;

   logic             w_idle;
   logic             w_grant0;
   logic             w_grant1;
   logic [SLICE:0]   w_slice;

   assign w_idle   = (r_state == IDLE);
   assign w_grant0 = req0_valid & (~req1_valid | ~r_rr);
   assign w_grant1 = req1_valid & (~req0_valid | r_rr);
   assign w_slice  = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_b[SLICE-1:0]} + (SLICE+1)'(r_carry);

   assign req0_ready = w_idle & w_grant0;
   assign req1_ready = w_idle & w_grant1;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_sum    = r_sum;
   assign rsp_id     = r_id;
   assign busy       = ~w_idle;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_k         <= '0;
         r_carry     <= 1'b0;
         r_rr        <= 1'b0;
         r_id        <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant0 | w_grant1) begin
                  r_a     <= w_grant1 ? req1_a : req0_a;
                  r_b     <= w_grant1 ? req1_b : req0_b;
                  r_id    <= w_grant1;
                  r_rr    <= ~w_grant1;
                  r_carry <= 1'b0;
                  r_k     <= '0;
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_a                <= r_a >> SLICE;
               r_b                <= r_b >> SLICE;
               r_carry            <= w_slice[SLICE];
               r_sum[WIDTH-1:0]   <= {w_slice[SLICE-1:0], r_sum[WIDTH-1:SLICE]};
               r_k                <= r_k + KW'(1);
               if (r_k == KW'(NSLC - 1)) begin
                  r_sum[WIDTH] <= w_slice[SLICE];
                  r_rsp_valid  <= 1'b1;
                  r_state      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_add_slice_sched.sv
// tb/tb_add_slice_sched.sv - directed self-checking bench for add_slice_sched
module tb_add_slice_sched;
   localparam int WIDTH = 12;
   localparam int SLICE = 3;
   localparam int NSLC  = WIDTH / SLICE;

   logic             clk;
   logic             rst;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic             rsp_valid, rsp_ready, rsp_id, busy;
   logic [WIDTH:0]   rsp_sum;

   int n_assert = 0;
   int n_fail   = 0;

   add_slice_sched #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single requester add with rsp_ready high: checks grant, latency, result and return to IDLE.
   task automatic run_add(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH:0] exp_sum);
      rsp_ready = 1'b1;
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
      #1;
      chk("ready_mine",  id ? req1_ready : req0_ready, 1);
      chk("ready_other", id ? req0_ready : req1_ready, 0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("busy_calc", busy, 1);
      for (int i = 1; i < NSLC; i++) begin
         tick();
         chk("rsp_early", rsp_valid, 0);
      end
      tick();
      chk("rsp_latency", rsp_valid, 1);
      chk("rsp_sum", rsp_sum, exp_sum);
      chk("rsp_id", rsp_id, id);
      tick();
      chk("rsp_drop", rsp_valid, 0);
      chk("busy_idle", busy, 0);
      chk("sum_hold", rsp_sum, exp_sum);
   endtask

   initial begin
      int waited;
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      rsp_ready = 1'b0;
      tick();
      tick();
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      tick();

      run_add(1'b0, 12'hFFF, 12'h001, 13'h1000);
      run_add(1'b1, 12'h5B6, 12'hA4A, 13'h1000);
      run_add(1'b0, 12'h123, 12'h456, 13'h0579);
      run_add(1'b1, 12'h000, 12'h000, 13'h0000);
      run_add(1'b0, 12'hFFF, 12'hFFF, 13'h1FFE);

      // Backpressure: hold the response, with requester 1 pending to show readies stay low.
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 12'h123; req0_b = 12'h456;
      #1;
      chk("bp_ready0", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      for (int i = 0; i < NSLC; i++) tick();
      req1_valid = 1'b1; req1_a = 12'h00F; req1_b = 12'h001;
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", rsp_valid, 1);
         chk("bp_sum", rsp_sum, 13'h0579);
         chk("bp_id", rsp_id, 0);
         chk("bp_ready_none", {req0_ready, req1_ready}, 0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_release_valid", rsp_valid, 0);
      chk("bp_release_busy", busy, 0);
      chk("bp_release_ready1", req1_ready, 1);
      chk("bp_release_sum", rsp_sum, 13'h0579);
      req1_valid = 1'b0;
      tick();

      // Reset in the second slice cycle; the accept of req0 moved rr to 1 beforehand.
      req0_valid = 1'b1; req0_a = 12'h123; req0_b = 12'h456;
      #1;
      chk("mid_ready0", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      tick();
      chk("mid_partial_sum", rsp_sum[WIDTH-1:WIDTH-SLICE], 3'h1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_sum", rsp_sum, 0);
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_id", rsp_id, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < NSLC + 2; i++) begin
         tick();
         chk("mid_no_rsp", rsp_valid, 0);
      end

      // Contention from reset: both valid continuously, grants must alternate starting at 0.
      req0_valid = 1'b1; req0_a = 12'h111; req0_b = 12'h222;
      req1_valid = 1'b1; req1_a = 12'h800; req1_b = 12'h900;
      #1;
      chk("rr_after_rst_ready0", req0_ready, 1);
      chk("rr_after_rst_ready1", req1_ready, 0);
      for (int g = 0; g < 4; g++) begin
         waited = 0;
         while (!(req0_ready || req1_ready) && waited < 20) begin
            chk("both_ready", req0_ready & req1_ready, 0);
            tick();
            waited++;
         end
         chk("grant_timeout", (waited < 20) ? 1 : 0, 1);
         chk("both_ready", req0_ready & req1_ready, 0);
         chk("grant_id", req1_ready, g % 2);
         tick();
         waited = 0;
         while (!rsp_valid && waited < 20) begin
            chk("both_ready", req0_ready & req1_ready, 0);
            tick();
            waited++;
         end
         chk("rsp_timeout", (waited < 20) ? 1 : 0, 1);
         chk("cont_rsp_id", rsp_id, g % 2);
         chk("cont_rsp_sum", rsp_sum, (g % 2) ? 13'h1100 : 13'h0333);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
